// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
//   state_e     : sweep FSM states
//   ROWS        : number of input combinations of a 3-input gate
//   SETTLE_MIN  : smallest hold time that still lets the synchronizer catch up
//   row_to_bit  : maps a row index {in1,in2,in3} to its bit in the hex gate name
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  localparam int unsigned ROWS       = 8;
  localparam int unsigned SETTLE_MIN = 3;

  // Row 000 is the MSB of the gate name, row 111 the LSB.
  function automatic logic [2:0] row_to_bit(input logic [2:0] row);
    return 3'd7 - row;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through all eight input rows, holds each row for SETTLE cycles,
// samples the gate output through a synchronizer and assembles the measured truth table
// in hex-name order, then compares it to a latched reference.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_i           : begin a sweep (accepted only when idle)
//   abort_i           : cancel a sweep in progress
//   expected_i        : reference truth table, latched on accepted start
//   gate_out_i        : gate output, asynchronous
//   in1_o/in2_o/in3_o : registered stimulus, {in1,in2,in3} = row
//   busy_o            : FSM not idle
//   done_o            : one-cycle pulse when the table is complete
//   tt_o              : measured truth table
//   tt_valid_o        : tt_o complete and paired with the latched reference
//   match_o           : tt_o equals the latched reference, gated by tt_valid_o
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] expected_i,
  input  logic       gate_out_i,
  output logic       in1_o,
  output logic       in2_o,
  output logic       in3_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] tt_o,
  output logic       tt_valid_o,
  output logic       match_o
);

  if (SETTLE < SETTLE_MIN || SETTLE > 255) begin : g_bad_settle
    $fatal(1, "truth_table_sweeper: SETTLE must be in 3..255");
  end

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tt_q, tt_d;
  logic       tt_valid_q, tt_valid_d;
  logic [7:0] exp_q, exp_d;
  logic       gate_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gate_out_i),
    .q_o   (gate_sync)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    tt_d       = tt_q;
    tt_valid_d = tt_valid_q;
    exp_d      = exp_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StDrive;
          row_d      = 3'd0;
          cnt_d      = 8'd0;
          tt_d       = 8'd0;
          tt_valid_d = 1'b0;
          exp_d      = expected_i;
        end
      end
      StDrive: begin
        if (abort_i) begin
          state_d = StIdle;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(SETTLE - 1)) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        if (abort_i) begin
          // Partial table is kept but never flagged valid.
          state_d = StIdle;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end else begin
          tt_d[row_to_bit(row_q)] = gate_sync;
          // Terminate before incrementing so the row counter never wraps.
          if (row_q == 3'(ROWS - 1)) begin
            state_d    = StDone;
            tt_valid_d = 1'b1;
          end else begin
            state_d = StDrive;
            row_d   = row_q + 3'd1;
            cnt_d   = 8'd0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= 3'd0;
      cnt_q      <= 8'd0;
      tt_q       <= 8'd0;
      tt_valid_q <= 1'b0;
      exp_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      tt_q       <= tt_d;
      tt_valid_q <= tt_valid_d;
      exp_q      <= exp_d;
    end
  end

  assign in1_o      = row_q[2];
  assign in2_o      = row_q[1];
  assign in3_o      = row_q[0];
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign tt_o       = tt_q;
  assign tt_valid_o = tt_valid_q;
  assign match_o    = tt_valid_q && (tt_q == exp_q);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. Instance A (SETTLE=8) sweeps a behavioural
// gate whose hex code is set per test; instance B (SETTLE=3) sees gate_out tied high.
// Reference: a correct sweep reports the gate's own hex code, each row holds for
// SETTLE+1 cycles, and done appears 8*(SETTLE+1) edges after the accepting edge
// (cycle 1+8*(SETTLE+1) when the start cycle is counted as cycle 0).
module tb_truth_table_sweeper;

  localparam int SA     = 8;
  localparam int SB     = 3;
  localparam int PER_A  = SA + 1;
  localparam int TOT_A  = 8 * PER_A;
  localparam int TOT_B  = 8 * (SB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start_a = 1'b0, abort_a = 1'b0;
  logic [7:0] expected_a = 8'd0;
  logic       gate_out_a;
  logic       in1_a, in2_a, in3_a, busy_a, done_a, tt_valid_a, match_a;
  logic [7:0] tt_a;

  logic       start_b = 1'b0;
  logic       abort_b = 1'b0;
  logic [7:0] expected_b = 8'hFF;
  logic       gate_out_b = 1'b1;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, tt_valid_b, match_b;
  logic [7:0] tt_b;

  logic [7:0] gate_code = 8'h00;
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Behavioural gate: the hex code lists outputs for rows 000..111, MSB first.
  logic [2:0] row_a;
  assign row_a      = {in1_a, in2_a, in3_a};
  assign gate_out_a = gate_code[7 - int'(row_a)];

  always #5 clk = ~clk;

  truth_table_sweeper #(.SETTLE(SA)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_a),
    .abort_i    (abort_a),
    .expected_i (expected_a),
    .gate_out_i (gate_out_a),
    .in1_o      (in1_a),
    .in2_o      (in2_a),
    .in3_o      (in3_a),
    .busy_o     (busy_a),
    .done_o     (done_a),
    .tt_o       (tt_a),
    .tt_valid_o (tt_valid_a),
    .match_o    (match_a)
  );

  truth_table_sweeper #(.SETTLE(SB)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_b),
    .abort_i    (abort_b),
    .expected_i (expected_b),
    .gate_out_i (gate_out_b),
    .in1_o      (in1_b),
    .in2_o      (in2_b),
    .in3_o      (in3_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .tt_o       (tt_b),
    .tt_valid_o (tt_valid_b),
    .match_o    (match_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_tt"}, 32'(tt_a), 32'd0);
    check({tag, "_ttv"}, 32'(tt_valid_a), 32'd0);
    check({tag, "_match"}, 32'(match_a), 32'd0);
    check({tag, "_stim"}, 32'(row_a), 32'd0);
  endtask

  // Advance n edges, sampling 1 time unit after each and counting done pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done_a) done_seen++;
    end
  endtask

  // Returns 1 time unit after the edge that accepts start.
  task automatic start_sweep(input logic [7:0] code, input logic [7:0] exp);
    @(negedge clk);
    gate_code  = code;
    expected_a = exp;
    start_a    = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic sweep_a(input logic [7:0] code, input logic [7:0] exp, input bit repulse,
                         input string tag);
    int done_k;
    int pulses;
    done_k = -1;
    pulses = 0;
    start_sweep(code, exp);
    for (int k = 0; k <= TOT_A + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      start_a = repulse && (k == 4 * PER_A + 1);
      if (k < TOT_A) check({tag, "_row"}, 32'(row_a), 32'(k / PER_A));
      if (done_a) begin
        pulses++;
        if (done_k < 0) done_k = k;
      end
      if (k == TOT_A) begin
        check({tag, "_tt"}, 32'(tt_a), 32'(code));
        check({tag, "_ttv"}, 32'(tt_valid_a), 32'd1);
        check({tag, "_match"}, 32'(match_a), 32'(code == exp));
        check({tag, "_busy_done"}, 32'(busy_a), 32'd1);
      end
      if (k == TOT_A + 1) begin
        check({tag, "_busy_after"}, 32'(busy_a), 32'd0);
        check({tag, "_stim_hold"}, 32'(row_a), 32'd7);
        check({tag, "_ttv_hold"}, 32'(tt_valid_a), 32'd1);
        check({tag, "_tt_hold"}, 32'(tt_a), 32'(code));
      end
    end
    start_a = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_k), 32'(TOT_A));
    check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_k;
    logic [7:0] code;
    logic [7:0] exp;

    // Reset state
    #1;
    check_idle_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check_idle_zero("post_reset");

    // Gate 0x20 against matching and non-matching references
    sweep_a(8'h20, 8'h20, 1'b0, "g20_match");
    sweep_a(8'h20, 8'hFE, 1'b0, "g20_nomatch");

    // gate_out tied high, SETTLE=3
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    done_k  = -1;
    for (int k = 0; k <= TOT_B + 1 && done_k < 0; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done_b) done_k = k;
    end
    check("ones_done_cycle", 32'(done_k), 32'(TOT_B));
    check("ones_tt", 32'(tt_b), 32'hFF);
    check("ones_match", 32'(match_b), 32'd1);
    check("ones_ttv", 32'(tt_valid_b), 32'd1);
    check("ones_stim", 32'({in1_b, in2_b, in3_b}), 32'd7);

    // Second start during row 4 is ignored
    sweep_a(8'h96, 8'h96, 1'b1, "restart_ignored");

    // Abort during row 3 DRIVE
    start_sweep(8'hB7, 8'hB7);
    step(3 * PER_A + 2);
    check("abort_pre_row", 32'(row_a), 32'd3);
    abort_a = 1'b1;
    done_seen = 0;
    step(1);
    abort_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_stim", 32'(row_a), 32'd0);
    check("abort_ttv", 32'(tt_valid_a), 32'd0);
    check("abort_match", 32'(match_a), 32'd0);
    check("abort_partial_tt", 32'(tt_a), 32'(8'hB7 & 8'hE0));
    step(TOT_A + 4);
    check("abort_no_done", 32'(done_seen), 32'd0);
    sweep_a(8'h5A, 8'h5A, 1'b0, "after_abort");

    // Asynchronous reset in the row 5 SAMPLE cycle
    start_sweep(8'hC3, 8'hC3);
    step(5 * PER_A + SA);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    step(TOT_A + 4);
    check("rst_no_done", 32'(done_seen), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);

    // Randomized gates and references
    for (int i = 0; i < 6; i++) begin
      code = 8'($urandom);
      exp  = ($urandom_range(0, 1) == 1) ? code : 8'($urandom);
      sweep_a(code, exp, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
